// File: rtl/sr_driver_pkg.sv
// sr_driver_pkg
//   Shared encodings for the SR flip-flop driver.
//   - FSM state encoding (IDLE, DRIVE, WAIT, ERROR)
//   - ERR_CODE values reported on the ERR_CODE output
package sr_driver_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_INVALID = 2'b10;

  // Width needed to hold (n-1), never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_driver_timer.sv
// sr_driver_timer
//   Loadable down-counter that stops at zero.
//   Ports:
//     CLK       clock, rising edge
//     RSTn      synchronous active-low reset (count -> 0)
//     load      load load_val (has priority over en)
//     load_val  value to load
//     en        decrement by one when non-zero
//     zero      count is zero
module sr_driver_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_driver.sv
// sr_driver
//   Command-side initiator for a clocked SR flip-flop. Accepts target-bit
//   requests over valid/ready, pulses S or R (never both), then watches the
//   Q/Qn feedback to confirm the transition, count it, or flag an error.
//   Ports:
//     CLK, RSTn            clock (rising edge), synchronous active-low reset
//     REQ_VALID/REQ_BIT    request and target Q value
//     REQ_READY            idle and able to accept a request
//     ERR_CLR              clears the ERROR state (sampled in ERROR only)
//     Q_FB/QN_FB           feedback from the driven flip-flop
//     S/R                  excitation outputs
//     DONE                 one-cycle completion pulse
//     ERR/ERR_CODE         sticky error flag and first-error code
//     TOGGLE_CNT           completed state changes, wraps
//
//   state | meaning
//   IDLE  | ready for a request; also finishes a no-drive request
//   DRIVE | holding S or R high for PULSE_W cycles
//   WAIT  | S=R=0, waiting up to TIMEOUT edges for Q_FB to reach target
//   ERROR | sticky fault, waiting for ERR_CLR
module sr_driver
  import sr_driver_pkg::*;
#(
  parameter int PULSE_W = 1,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             REQ_VALID,
  input  logic             REQ_BIT,
  output logic             REQ_READY,
  input  logic             ERR_CLR,
  input  logic             Q_FB,
  input  logic             QN_FB,
  output logic             S,
  output logic             R,
  output logic             DONE,
  output logic             ERR,
  output logic [1:0]       ERR_CODE,
  output logic [CNT_W-1:0] TOGGLE_CNT
);

  localparam int PW_W = cnt_width(PULSE_W);
  localparam int TO_W = cnt_width(TIMEOUT);
  // Timers are loaded with N-1 so their zero flag marks the N-th edge.
  localparam logic [PW_W-1:0] PW_LOAD = PW_W'(PULSE_W - 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  logic [1:0]       state, state_nxt;
  logic             target, target_nxt;
  logic             skip_pend, skip_pend_nxt;
  logic             s_nxt, r_nxt, ready_nxt, done_nxt, err_nxt;
  logic [1:0]       code_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  logic pw_load, pw_en, pw_zero;
  logic to_load, to_en, to_zero;
  logic accept, fb_valid, fb_match, already_there;

  assign accept        = (state == ST_IDLE) && REQ_READY && REQ_VALID;
  assign fb_valid      = (Q_FB != QN_FB);
  assign fb_match      = (Q_FB == target);
  assign already_there = (REQ_BIT == Q_FB) && fb_valid;

  sr_driver_timer #(.W(PW_W)) u_pulse_timer (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .load     (pw_load),
    .load_val (PW_LOAD),
    .en       (pw_en),
    .zero     (pw_zero)
  );

  sr_driver_timer #(.W(TO_W)) u_timeout_timer (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .load     (to_load),
    .load_val (TO_LOAD),
    .en       (to_en),
    .zero     (to_zero)
  );

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= ST_IDLE;
      target     <= 1'b0;
      skip_pend  <= 1'b0;
      S          <= 1'b0;
      R          <= 1'b0;
      REQ_READY  <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      ERR_CODE   <= ERR_NONE;
      TOGGLE_CNT <= '0;
    end else begin
      state      <= state_nxt;
      target     <= target_nxt;
      skip_pend  <= skip_pend_nxt;
      S          <= s_nxt;
      R          <= r_nxt;
      REQ_READY  <= ready_nxt;
      DONE       <= done_nxt;
      ERR        <= err_nxt;
      ERR_CODE   <= code_nxt;
      TOGGLE_CNT <= cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && !already_there) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (pw_zero) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!fb_valid)    state_nxt = ST_ERROR;
        else if (fb_match) state_nxt = ST_IDLE;
        else if (to_zero)  state_nxt = ST_ERROR;
      end
      ST_ERROR: begin
        if (ERR_CLR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and timer controls.
  always_comb begin
    target_nxt    = target;
    skip_pend_nxt = 1'b0;
    s_nxt         = 1'b0;
    r_nxt         = 1'b0;
    ready_nxt     = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = ERR;
    code_nxt      = ERR_CODE;
    cnt_nxt       = TOGGLE_CNT;
    pw_load       = 1'b0;
    pw_en         = 1'b0;
    to_load       = 1'b0;
    to_en         = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_nxt = 1'b1;
        if (skip_pend) begin
          // Target already held: complete one edge after accept, no count.
          done_nxt = 1'b1;
        end else if (accept) begin
          target_nxt = REQ_BIT;
          ready_nxt  = 1'b0;
          if (already_there) begin
            skip_pend_nxt = 1'b1;
          end else begin
            s_nxt   = REQ_BIT;
            r_nxt   = ~REQ_BIT;
            pw_load = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        pw_en = 1'b1;
        if (pw_zero) begin
          to_load = 1'b1;
        end else begin
          s_nxt = target;
          r_nxt = ~target;
        end
      end
      ST_WAIT: begin
        to_en = 1'b1;
        if (!fb_valid) begin
          err_nxt  = 1'b1;
          code_nxt = ERR_INVALID;
        end else if (fb_match) begin
          done_nxt  = 1'b1;
          ready_nxt = 1'b1;
          cnt_nxt   = TOGGLE_CNT + CNT_W'(1);
        end else if (to_zero) begin
          err_nxt  = 1'b1;
          code_nxt = ERR_TIMEOUT;
        end
      end
      ST_ERROR: begin
        if (ERR_CLR) begin
          err_nxt   = 1'b0;
          code_nxt  = ERR_NONE;
          ready_nxt = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sr_driver.sv
// tb_sr_driver
//   Directed bench for sr_driver. Two instances share the clock:
//   dut_a (PULSE_W=1, TIMEOUT=8, CNT_W=2) and dut_b (PULSE_W=3, TIMEOUT=4,
//   CNT_W=8). Each is looped back through a behavioural SR flip-flop whose
//   feedback can be overridden to model stuck or invalid outputs.
module tb_sr_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int sr_both  = 0;

  // dut_a signals
  logic       a_rstn = 1'b0, a_valid = 1'b0, a_bit = 1'b0, a_clr = 1'b0;
  logic       a_force = 1'b0, a_fq = 1'b0, a_fqn = 1'b1;
  logic       a_q = 1'b0;
  logic       a_qfb, a_qnfb;
  logic       a_ready, a_s, a_r, a_done, a_err;
  logic [1:0] a_code;
  logic [1:0] a_cnt;

  // dut_b signals
  logic       b_rstn = 1'b0, b_valid = 1'b0, b_bit = 1'b0, b_clr = 1'b0;
  logic       b_force = 1'b0, b_fq = 1'b0, b_fqn = 1'b1;
  logic       b_q = 1'b0;
  logic       b_qfb, b_qnfb;
  logic       b_ready, b_s, b_r, b_done, b_err;
  logic [1:0] b_code;
  logic [7:0] b_cnt;

  // Behavioural SR flip-flops used as loopback responders.
  always @(posedge clk) begin
    if (a_s) a_q <= 1'b1;
    else if (a_r) a_q <= 1'b0;
    if (b_s) b_q <= 1'b1;
    else if (b_r) b_q <= 1'b0;
  end

  assign a_qfb  = a_force ? a_fq  : a_q;
  assign a_qnfb = a_force ? a_fqn : ~a_q;
  assign b_qfb  = b_force ? b_fq  : b_q;
  assign b_qnfb = b_force ? b_fqn : ~b_q;

  always @(negedge clk) begin
    if ((a_s & a_r) | (b_s & b_r)) sr_both++;
  end

  sr_driver #(.PULSE_W(1), .TIMEOUT(8), .CNT_W(2)) dut_a (
    .CLK        (clk),
    .RSTn       (a_rstn),
    .REQ_VALID  (a_valid),
    .REQ_BIT    (a_bit),
    .REQ_READY  (a_ready),
    .ERR_CLR    (a_clr),
    .Q_FB       (a_qfb),
    .QN_FB      (a_qnfb),
    .S          (a_s),
    .R          (a_r),
    .DONE       (a_done),
    .ERR        (a_err),
    .ERR_CODE   (a_code),
    .TOGGLE_CNT (a_cnt)
  );

  sr_driver #(.PULSE_W(3), .TIMEOUT(4), .CNT_W(8)) dut_b (
    .CLK        (clk),
    .RSTn       (b_rstn),
    .REQ_VALID  (b_valid),
    .REQ_BIT    (b_bit),
    .REQ_READY  (b_ready),
    .ERR_CLR    (b_clr),
    .Q_FB       (b_qfb),
    .QN_FB      (b_qnfb),
    .S          (b_s),
    .R          (b_r),
    .DONE       (b_done),
    .ERR        (b_err),
    .ERR_CODE   (b_code),
    .TOGGLE_CNT (b_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rstn = 1'b0;
    b_rstn = 1'b0;
    step();
    step();
    n_checks++;
    if ({a_s, a_r, a_ready, a_done, a_err, a_code, a_cnt} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b want 0", {a_s, a_r, a_ready, a_done, a_err, a_code, a_cnt});
    end
    n_checks++;
    if ({b_s, b_r, b_ready, b_done, b_err, b_code, b_cnt} !== 15'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b want 0", {b_s, b_r, b_ready, b_done, b_err, b_code, b_cnt});
    end
    a_rstn = 1'b1;
    b_rstn = 1'b1;
    step();
    n_checks++;
    if ({a_ready, b_ready, a_s, a_r, b_s, b_r} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 110000", {a_ready, b_ready, a_s, a_r, b_s, b_r});
    end
  endtask

  // PULSE_W=1 toggle: S/R for one cycle, DONE two edges after accept.
  task automatic test_toggle(input logic bit_val, input logic [1:0] exp_cnt);
    a_bit   = bit_val;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    n_checks++;
    if ({a_s, a_r, a_ready, a_done} !== {bit_val, ~bit_val, 2'b00}) begin
      n_fail++;
      $display("FAIL toggle_accept: got %b want %b", {a_s, a_r, a_ready, a_done}, {bit_val, ~bit_val, 2'b00});
    end
    step();
    n_checks++;
    if ({a_s, a_r, a_done, a_q} !== {3'b000, bit_val}) begin
      n_fail++;
      $display("FAIL toggle_pulse_end: got %b want %b", {a_s, a_r, a_done, a_q}, {3'b000, bit_val});
    end
    step();
    n_checks++;
    if ({a_done, a_ready, a_cnt} !== {2'b11, exp_cnt}) begin
      n_fail++;
      $display("FAIL toggle_done: got %b want %b", {a_done, a_ready, a_cnt}, {2'b11, exp_cnt});
    end
    step();
    n_checks++;
    if (a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_done_pulse: got %b want 0", a_done);
    end
  endtask

  task automatic test_noop();
    a_bit   = 1'b0;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    n_checks++;
    if ({a_s, a_r, a_ready, a_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL noop_accept: got %b want 0000", {a_s, a_r, a_ready, a_done});
    end
    step();
    n_checks++;
    if ({a_s, a_r, a_ready, a_done, a_cnt} !== 6'b001110) begin
      n_fail++;
      $display("FAIL noop_done: got %b want 001110", {a_s, a_r, a_ready, a_done, a_cnt});
    end
    step();
    n_checks++;
    if (a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL noop_done_pulse: got %b want 0", a_done);
    end
  endtask

  // REQ_VALID held high throughout; five alternating toggles, CNT_W=2 wrap.
  task automatic test_back_to_back();
    logic [1:0] exp_cnt [5];
    int n_drive;
    int n_done;
    int cyc;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    n_drive = 0;
    n_done  = 0;
    a_rstn  = 1'b0;
    step();
    a_valid = 1'b1;
    a_bit   = 1'b1;
    a_rstn  = 1'b1;
    step();
    n_checks++;
    if ({a_ready, a_s, a_r} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_release: got %b want 100", {a_ready, a_s, a_r});
    end
    for (int i = 0; i < 5; i++) begin
      cyc = 0;
      do begin
        step();
        cyc++;
        if (a_s | a_r) n_drive++;
      end while (!a_done && cyc < 10);
      n_checks++;
      if ({a_done, a_cnt, cyc[3:0]} !== {1'b1, exp_cnt[i], 4'd3}) begin
        n_fail++;
        $display("FAIL b2b_req%0d: done=%b cnt=%0d cycles=%0d want done=1 cnt=%0d cycles=3",
                 i, a_done, a_cnt, cyc, exp_cnt[i]);
      end
      a_bit = ~a_bit;
    end
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_s | a_r) n_drive++;
      if (a_done) n_done++;
    end
    n_checks++;
    if (n_drive !== 5 || n_done !== 0 || a_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL b2b_no_double_accept: drives=%0d extra_done=%0d cnt=%0d want 5 0 1",
               n_drive, n_done, a_cnt);
    end
  endtask

  // PULSE_W=3, TIMEOUT=4, feedback stuck at Q=0.
  task automatic test_timeout();
    int n_s;
    int n_done;
    n_s     = 0;
    n_done  = 0;
    b_force = 1'b1;
    b_fq    = 1'b0;
    b_fqn   = 1'b1;
    b_bit   = 1'b1;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    if (b_s) n_s++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b_s) n_s++;
      if (b_done) n_done++;
    end
    n_checks++;
    if (n_s !== 3 || n_done !== 0 || b_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: s_cycles=%0d done=%0d err=%b want 3 0 0", n_s, n_done, b_err);
    end
    step();
    n_checks++;
    if ({b_err, b_code, b_ready, b_s, b_r} !== 6'b101000) begin
      n_fail++;
      $display("FAIL timeout_error: got %b want 101000", {b_err, b_code, b_ready, b_s, b_r});
    end
    b_fq = 1'b1;
    step();
    n_checks++;
    if ({b_err, b_code, b_ready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL timeout_code_sticky: got %b want 1010", {b_err, b_code, b_ready});
    end
    b_fq  = 1'b0;
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    n_checks++;
    if ({b_err, b_code, b_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b want 0001", {b_err, b_code, b_ready});
    end
  endtask

  task automatic test_invalid_fb();
    b_bit   = 1'b1;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    step();
    step();
    n_checks++;
    if ({b_s, b_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL invalid_in_wait: got %b want 00", {b_s, b_err});
    end
    b_fq  = 1'b1;
    b_fqn = 1'b1;
    step();
    n_checks++;
    if ({b_err, b_code, b_ready, b_done} !== 5'b11000) begin
      n_fail++;
      $display("FAIL invalid_error: got %b want 11000", {b_err, b_code, b_ready, b_done});
    end
    b_force = 1'b0;
    b_clr   = 1'b1;
    step();
    b_clr = 1'b0;
    n_checks++;
    if ({b_err, b_code, b_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL invalid_clear: got %b want 0001", {b_err, b_code, b_ready});
    end
  endtask

  // PULSE_W=3 latency, then reset asserted while S is being driven.
  task automatic test_reset_mid_drive();
    int cyc;
    cyc     = 0;
    b_bit   = 1'b0;
    b_valid = 1'b1;
    do begin
      step();
      b_valid = 1'b0;
      cyc++;
    end while (!b_done && cyc < 12);
    n_checks++;
    if (b_done !== 1'b1 || cyc !== 5 || b_cnt !== 8'd1 || b_q !== 1'b0) begin
      n_fail++;
      $display("FAIL pw3_latency: done=%b cycles=%0d cnt=%0d q=%b want 1 5 1 0", b_done, cyc, b_cnt, b_q);
    end
    b_bit   = 1'b1;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    n_checks++;
    if ({b_s, b_r} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_drive_s: got %b want 10", {b_s, b_r});
    end
    b_rstn = 1'b0;
    step();
    n_checks++;
    if ({b_s, b_r, b_ready, b_done, b_err, b_code, b_cnt} !== 15'b0) begin
      n_fail++;
      $display("FAIL mid_drive_reset: got %b want 0", {b_s, b_r, b_ready, b_done, b_err, b_code, b_cnt});
    end
    b_rstn = 1'b1;
    step();
    n_checks++;
    if ({b_ready, b_s, b_r} !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_drive_release: got %b want 100", {b_ready, b_s, b_r});
    end
  endtask

  task automatic test_sr_exclusive();
    n_checks++;
    if (sr_both !== 0) begin
      n_fail++;
      $display("FAIL sr_exclusive: S&R high on %0d cycles, want 0", sr_both);
    end
  endtask

  initial begin
    test_reset();
    test_toggle(1'b1, 2'd1);
    test_toggle(1'b0, 2'd2);
    test_noop();
    test_back_to_back();
    test_timeout();
    test_invalid_fb();
    test_reset_mid_drive();
    test_sr_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
